nalu_funnel_shifter: RTL and testbench

//  Parametrised, clocked successor to the cartridge protection ALU.
//  CPU write strobes load a shift amount or push a data word into a DEPTH-entry window FIFO.
//  A registered funnel-shift result is driven back on the CPU data bus during read cycles.

---
 rtl/nalu_pkg.sv | 13 +
 rtl/nalu_strobe_sync.sv | 23 ++
 rtl/nalu_funnel_shifter.sv | 123 ++++++++++++
 tb/tb_nalu_funnel_shifter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/nalu_pkg.sv
// Shared constants for the cartridge funnel-shifter ALU: opcode, default geometry
// and the shift-register width helper.
package nalu_pkg;

  localparam logic [2:0] NALU_OPCODE = 3'b000;
  localparam int         NALU_WIDTH  = 8;
  localparam int         NALU_DEPTH  = 2;

  function automatic int shw_f(input int width, input int depth);
    return $clog2(width * depth);
  endfunction

endpackage

// File: rtl/nalu_strobe_sync.sv
// Brings an asynchronous CPU write strobe into the clk domain and emits a
// one-clock pulse on its synchronised rising edge.
module nalu_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);

  logic [2:0] sync_r;

  // two metastability stages plus one history stage for the edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], strobe};
    end
  end

  assign pulse = sync_r[1] & ~sync_r[2];

endmodule

// File: rtl/nalu_funnel_shifter.sv
// Clocked funnel-shifter protection ALU: strobe-loaded window FIFO and shift register,
// registered funnel result. Define NALU_ROTATE_EN for rotate mode instead of clamped shift.
module nalu_funnel_shifter
  import nalu_pkg::*;
#(
  parameter int WIDTH = NALU_WIDTH,
  parameter int DEPTH = NALU_DEPTH,
  parameter int SHW   = shw_f(WIDTH, DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           bus_din,
  input  logic                       wr_shift,
  input  logic                       wr_data,
  input  logic                       mode,
  output logic [WIDTH-1:0]           bus_dout,
  output logic                       bus_oe,
  output logic [2:0]                 opcode,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       win_full
);

  localparam int                WINW     = DEPTH * WIDTH;
  localparam int                CNTW     = $clog2(DEPTH + 1);
  localparam logic [CNTW-1:0]   FULL_CNT = CNTW'(DEPTH);

  logic             shift_pulse_s;
  logic             data_pulse_s;
  logic [WIDTH-1:0] entry_r [DEPTH];
  logic [SHW-1:0]   shreg_r;
  logic [CNTW-1:0]  fill_r;
  logic [WIDTH-1:0] dout_r;
  logic [WINW-1:0]  window_s;
  logic [WINW-1:0]  shifted_s;
  logic [SHW-1:0]   amt_s;

  nalu_strobe_sync u_sync_shift (
    .clk    (clk),
    .rst_n  (reset),
    .strobe (wr_shift),
    .pulse  (shift_pulse_s)
  );

  nalu_strobe_sync u_sync_data (
    .clk    (clk),
    .rst_n  (reset),
    .strobe (wr_data),
    .pulse  (data_pulse_s)
  );

  // window FIFO, fill counter and shift register; both strobes may act in one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) entry_r[i] <= '0;
      shreg_r <= '0;
      fill_r  <= '0;
    end else begin
      if (data_pulse_s) begin
        for (int i = 0; i < DEPTH - 1; i++) entry_r[i] <= entry_r[i+1];
        entry_r[DEPTH-1] <= bus_din;
        if (fill_r != FULL_CNT) begin
          fill_r <= fill_r + 1'b1;
        end else begin
          fill_r <= fill_r;
        end
      end else begin
        fill_r <= fill_r;
      end
      if (shift_pulse_s) begin
        shreg_r <= bus_din[SHW-1:0];
      end else begin
        shreg_r <= shreg_r;
      end
    end
  end

  // newest entry lands in the MSBs of the window
  always_comb begin
    window_s = '0;
    for (int i = 0; i < DEPTH; i++) window_s[i*WIDTH +: WIDTH] = entry_r[i];
  end

`ifdef NALU_ROTATE_EN
  logic [2*WINW-1:0] double_s;

  // rotate left by shreg modulo the window width, using a doubled window
  always_comb begin
    amt_s     = SHW'(32'(shreg_r) % 32'(WINW));
    double_s  = {window_s, window_s} << amt_s;
    shifted_s = double_s[2*WINW-1 -: WINW];
  end
`else
  localparam logic [SHW-1:0] MAX_SH = SHW'((DEPTH - 1) * WIDTH);

  // zero-fill shift; large counts clamp so the result always comes from the oldest word
  always_comb begin
    if (shreg_r > MAX_SH) begin
      amt_s = MAX_SH;
    end else begin
      amt_s = shreg_r;
    end
    shifted_s = window_s << amt_s;
  end
`endif

  // result register follows the window every cycle while the CPU is reading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_r <= '0;
    end else if (!mode) begin
      dout_r <= shifted_s[WINW-1 -: WIDTH];
    end else begin
      dout_r <= dout_r;
    end
  end

  assign bus_dout = dout_r;
  assign bus_oe   = !mode && reset;
  assign opcode   = NALU_OPCODE;
  assign fill_cnt = fill_r;
  assign win_full = (fill_r == FULL_CNT);

endmodule

// File: tb/tb_nalu_funnel_shifter.sv
// Scoreboard bench for nalu_funnel_shifter (WIDTH=8, DEPTH=2); honours NALU_ROTATE_EN.
module tb_nalu_funnel_shifter;

  logic       clk;
  logic       reset;
  logic [7:0] bus_din;
  logic       wr_shift;
  logic       wr_data;
  logic       mode;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic [2:0] opcode;
  logic [1:0] fill_cnt;
  logic       win_full;

  int checks_r   = 0;
  int failures_r = 0;

  logic [7:0] sb_q[$];
  logic [7:0] m_e0, m_e1, m_prev;
  logic [3:0] m_sh;
  int         m_cnt;

  nalu_funnel_shifter dut (
    .clk      (clk),
    .reset    (reset),
    .bus_din  (bus_din),
    .wr_shift (wr_shift),
    .wr_data  (wr_data),
    .mode     (mode),
    .bus_dout (bus_dout),
    .bus_oe   (bus_oe),
    .opcode   (opcode),
    .fill_cnt (fill_cnt),
    .win_full (win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      failures_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_result(input logic [7:0] e1, input logic [7:0] e0,
                                              input logic [3:0] sh);
    logic [31:0] w;
    logic [31:0] r;
    int          s;
    w = {16'h0000, e1, e0};
`ifdef NALU_ROTATE_EN
    s = int'(sh);
    r = ((w << s) | (w >> (16 - s))) & 32'h0000_FFFF;
    return r[15:8];
`else
    s = (int'(sh) > 8) ? 8 : int'(sh);
    r = (w << s) & 32'h0000_FFFF;
    return r[15:8];
`endif
  endfunction

  task automatic model_reset();
    m_e0 = 8'h00; m_e1 = 8'h00; m_sh = 4'h0; m_cnt = 0; m_prev = 8'h00;
  endtask

  task automatic model_apply(input logic do_push, input logic do_shift, input logic [7:0] val);
    if (do_push) begin
      m_e0 = m_e1;
      m_e1 = val;
      if (m_cnt < 2) m_cnt++;
    end
    if (do_shift) m_sh = val[3:0];
    sb_q.push_back(model_result(m_e1, m_e0, m_sh));
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(tag, {24'h0, bus_dout}, {24'h0, e});
      m_prev = e;
    end
  endtask

  // one strobe transaction: result must lag exactly four edges behind the strobe
  task automatic do_op(input string tag, input logic do_push, input logic do_shift,
                       input logic [7:0] val);
    model_apply(do_push, do_shift, val);
    @(negedge clk);
    bus_din  = val;
    wr_data  = do_push;
    wr_shift = do_shift;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold3"}, {24'h0, bus_dout}, {24'h0, m_prev});
    chk({tag, "_fill"}, {30'h0, fill_cnt}, 32'(m_cnt));
    @(posedge clk);
    #1;
    pop_check(tag);
    chk({tag, "_full"}, {31'h0, win_full}, {31'h0, (m_cnt == 2)});
    @(negedge clk);
    wr_data  = 1'b0;
    wr_shift = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset = 1'b0; bus_din = 8'h00; wr_shift = 1'b0; wr_data = 1'b0; mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", {24'h0, bus_dout}, 32'h0);
    chk("rst_fill", {30'h0, fill_cnt}, 32'h0);
    chk("rst_full", {31'h0, win_full}, 32'h0);
    chk("rst_oe", {31'h0, bus_oe}, 32'h0);
    chk("opcode", {29'h0, opcode}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("oe_release", {31'h0, bus_oe}, 32'h1);

    do_op("push_a5", 1'b1, 1'b0, 8'hA5);
    do_op("push_3c", 1'b1, 1'b0, 8'h3C);
    do_op("sh3", 1'b0, 1'b1, 8'h03);
    do_op("sh0", 1'b0, 1'b1, 8'h00);
    do_op("sh8", 1'b0, 1'b1, 8'h08);
    do_op("sh12", 1'b0, 1'b1, 8'h0C);
    do_op("push_77", 1'b1, 1'b0, 8'h77);
    do_op("sh0_b", 1'b0, 1'b1, 8'h00);
    do_op("sh8_b", 1'b0, 1'b1, 8'h08);
    do_op("both_02", 1'b1, 1'b1, 8'h02);

    // result register freezes while the bus is not being read
    @(negedge clk);
    mode = 1'b1;
    #1;
    chk("oe_mode1", {31'h0, bus_oe}, 32'h0);
    model_apply(1'b0, 1'b1, 8'h00);
    bus_din  = 8'h00;
    wr_shift = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mode1_hold", {24'h0, bus_dout}, {24'h0, m_prev});
    @(negedge clk);
    wr_shift = 1'b0;
    mode     = 1'b0;
    @(posedge clk);
    #1;
    pop_check("mode0_resume");
    repeat (3) @(posedge clk);

    // reset mid-synchronisation discards the pending push
    @(negedge clk);
    bus_din = 8'h99;
    wr_data = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_data = 1'b0;
    reset   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_fill", {30'h0, fill_cnt}, 32'h0);
    chk("midrst_dout", {24'h0, bus_dout}, 32'h0);
    chk("midrst_full", {31'h0, win_full}, 32'h0);

    // a strobe glitch that never spans a clock edge must not push
    @(negedge clk);
    bus_din = 8'h44;
    #1 wr_data = 1'b1;
    #2 wr_data = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("glitch_fill", {30'h0, fill_cnt}, 32'h0);

    do_op("post_rst_push", 1'b1, 1'b0, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
